// File: rtl/fetch_redirect_unit.sv
// Dual-issue fetch PC generator: issues (pc, pc+4) request pairs and restarts fetch
// at the resolved branch target, squashing the front end for FLUSH_CYCLES cycles.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid1,
  input  logic        ex_valid2,
  input  logic        isBranchTaken1,
  input  logic        isBranchTaken2,
  input  logic [31:0] branchPC1,
  input  logic [31:0] branchPC2,
  output logic        imem_req,
  output logic [31:0] imem_addr1,
  output logic [31:0] imem_addr2,
  input  logic        imem_ready,
  output logic        fetch_valid1,
  output logic        fetch_valid2,
  output logic [31:0] fetch_pc1,
  output logic [31:0] fetch_pc2,
  output logic        flush,
  output logic        kill2,
  output logic [15:0] redirect_count
);

  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [3:0]  cnt_q;
  logic        flush_q;
  logic        fv_q;
  logic [31:0] fpc1_q;
  logic [31:0] fpc2_q;
  logic [15:0] rcnt_q;

  logic        take1;
  logic        take2;
  logic        redirect;
  logic        accept;
  logic [31:0] target_d;
  logic [31:0] pc_seq_d;

  // Lane 1 is older, so its taken branch overrides lane 2 and squashes lane 2's writeback.
  assign take1    = ex_valid1 && isBranchTaken1;
  assign take2    = ex_valid2 && isBranchTaken2;
  assign redirect = take1 || take2;
  assign target_d = (take1 ? branchPC1 : branchPC2) & 32'hFFFF_FFFC;
  assign kill2    = take1;

  assign imem_req   = !rst && (state_q == RUN) && !stall;
  assign accept     = imem_req && imem_ready;
  assign imem_addr1 = pc_q;
  assign imem_addr2 = pc_q + 32'd4;
  assign pc_seq_d   = pc_q + 32'd8;

  assign fetch_valid1   = fv_q;
  assign fetch_valid2   = fv_q;
  assign fetch_pc1      = fpc1_q;
  assign fetch_pc2      = fpc2_q;
  assign flush          = flush_q;
  assign redirect_count = rcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= 4'd0;
      flush_q <= 1'b0;
      fv_q    <= 1'b0;
      fpc1_q  <= 32'd0;
      fpc2_q  <= 32'd0;
      rcnt_q  <= 16'd0;
    end else if (redirect) begin
      // Redirect beats stall, imem_ready and any accept happening this same cycle.
      state_q <= FLUSH;
      pc_q    <= target_d;
      cnt_q   <= CNT_INIT;
      flush_q <= 1'b1;
      fv_q    <= 1'b0;
      rcnt_q  <= rcnt_q + 16'd1;
    end else begin
      case (state_q)
        FLUSH: begin
          if (cnt_q == 4'd0) begin
            flush_q <= 1'b0;
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          if (accept) begin
            fpc1_q <= pc_q;
            fpc2_q <= imem_addr2;
            fv_q   <= 1'b1;
            pc_q   <= pc_seq_d;
          end else if (!stall) begin
            fv_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a cycle-indexed behavioural model.
module tb_fetch_redirect_unit;

  localparam int          FC  = 2;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst, stall, imem_ready;
  logic        ex_valid1, ex_valid2, isBranchTaken1, isBranchTaken2;
  logic [31:0] branchPC1, branchPC2;
  logic        imem_req, fetch_valid1, fetch_valid2, flush, kill2;
  logic [31:0] imem_addr1, imem_addr2, fetch_pc1, fetch_pc2;
  logic [15:0] redirect_count;

  int checks = 0;
  int errors = 0;

  fetch_redirect_unit #(.RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_valid1(ex_valid1), .ex_valid2(ex_valid2),
    .isBranchTaken1(isBranchTaken1), .isBranchTaken2(isBranchTaken2),
    .branchPC1(branchPC1), .branchPC2(branchPC2),
    .imem_req(imem_req), .imem_addr1(imem_addr1), .imem_addr2(imem_addr2),
    .imem_ready(imem_ready),
    .fetch_valid1(fetch_valid1), .fetch_valid2(fetch_valid2),
    .fetch_pc1(fetch_pc1), .fetch_pc2(fetch_pc2),
    .flush(flush), .kill2(kill2), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the flush window is tracked as an absolute cycle index.
  int          cyc    = 0;
  int          m_fend = -1;
  bit          m_ok   = 0;
  logic [31:0] m_pc, m_fpc1, m_fpc2;
  logic        m_fv;
  logic [15:0] m_rc;
  logic        e_flush, e_req, e_red;
  logic [31:0] e_tgt;

  always @(negedge clk) begin
    e_flush = (cyc <= m_fend);
    e_req   = !rst && !e_flush && !stall;
    if (m_ok) begin
      check("imem_req", imem_req, e_req);
      check("imem_addr1", imem_addr1, m_pc);
      check("imem_addr2", imem_addr2, m_pc + 32'd4);
      check("kill2", kill2, ex_valid1 && isBranchTaken1);
      check("fetch_valid1", fetch_valid1, m_fv);
      check("fetch_valid2", fetch_valid2, m_fv);
      check("fetch_pc1", fetch_pc1, m_fpc1);
      check("fetch_pc2", fetch_pc2, m_fpc2);
      check("flush", flush, e_flush);
      check("redirect_count", redirect_count, m_rc);
    end
    e_red = (ex_valid1 && isBranchTaken1) || (ex_valid2 && isBranchTaken2);
    e_tgt = (ex_valid1 && isBranchTaken1) ? branchPC1 : branchPC2;
    if (rst) begin
      m_ok = 1; m_pc = RPC; m_fv = 0; m_fpc1 = 0; m_fpc2 = 0; m_rc = 0; m_fend = cyc;
    end else if (e_red) begin
      m_pc = {e_tgt[31:2], 2'b00}; m_fv = 0; m_rc = m_rc + 16'd1; m_fend = cyc + FC;
    end else if (!e_flush && !stall) begin
      if (imem_ready) begin
        m_fpc1 = m_pc; m_fpc2 = m_pc + 32'd4; m_fv = 1; m_pc = m_pc + 32'd8;
      end else begin
        m_fv = 0;
      end
    end
    cyc++;
  end

  // One cycle of stimulus; returns shortly after the inputs settle.
  task automatic step(input logic r, s, rdy, v1, t1, input logic [31:0] b1,
                      input logic v2, t2, input logic [31:0] b2);
    @(posedge clk);
    #2;
    rst = r; stall = s; imem_ready = rdy;
    ex_valid1 = v1; isBranchTaken1 = t1; branchPC1 = b1;
    ex_valid2 = v2; isBranchTaken2 = t2; branchPC2 = b2;
    #1;
  endtask

  task automatic idle(input logic s, input logic rdy);
    step(1'b0, s, rdy, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] hold_pc1;
    rst = 1; stall = 0; imem_ready = 0;
    ex_valid1 = 0; ex_valid2 = 0; isBranchTaken1 = 0; isBranchTaken2 = 0;
    branchPC1 = 0; branchPC2 = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst imem_req", imem_req, 0);

    // Streaming from reset
    idle(0, 1);
    check("reset addr1", imem_addr1, 32'h100);
    check("reset addr2", imem_addr2, 32'h104);
    check("reset fetch_valid", fetch_valid1, 0);
    check("reset flush", flush, 0);
    check("reset count", redirect_count, 0);
    check("reset fetch_pc1", fetch_pc1, 0);

    // Lane-1 redirect collides with an accept of 0x108
    step(0, 0, 1, 1, 1, 32'h2003, 1, 1, 32'h3000);
    check("stream addr1", imem_addr1, 32'h108);
    check("stream fetch_pc1", fetch_pc1, 32'h100);
    check("stream fetch_pc2", fetch_pc2, 32'h104);
    check("stream fetch_valid", fetch_valid2, 1);
    check("lane1 kill2", kill2, 1);
    idle(0, 1);
    check("redir flush c1", flush, 1);
    check("redir dropped pair", fetch_valid1, 0);
    check("redir req off", imem_req, 0);
    idle(0, 1);
    check("redir flush c2", flush, 1);
    idle(0, 1);
    check("redir flush end", flush, 0);
    check("redir target addr1", imem_addr1, 32'h2000);
    check("redir target addr2", imem_addr2, 32'h2004);
    check("redir count", redirect_count, 1);

    // Lane-2-only redirect
    step(0, 0, 1, 1, 0, 32'h0, 1, 1, 32'h400);
    check("lane2 kill2", kill2, 0);
    check("lane2 fetch_pc1", fetch_pc1, 32'h2000);
    idle(0, 1); idle(0, 1); idle(0, 1);
    check("lane2 target", imem_addr1, 32'h400);
    check("lane2 count", redirect_count, 2);

    // Stall three cycles, then imem_ready low two cycles
    for (int i = 0; i < 3; i++) begin
      idle(1, 1);
      check("stall req", imem_req, 0);
      check("stall fetch_pc1", fetch_pc1, 32'h400);
      check("stall fetch_valid", fetch_valid1, 1);
    end
    idle(0, 0);
    check("notready addr1", imem_addr1, 32'h408);
    idle(0, 0);
    check("notready fv", fetch_valid1, 0);
    idle(0, 1);
    check("notready addr hold", imem_addr1, 32'h408);
    check("notready fv2", fetch_valid2, 0);
    idle(0, 1);
    check("resume fetch_pc1", fetch_pc1, 32'h408);

    // Redirect under stall, then a second redirect inside the flush window
    step(0, 1, 1, 1, 1, 32'h500, 0, 0, 32'h0);
    step(0, 0, 1, 0, 0, 32'h0, 1, 1, 32'h601);
    check("reflush flush", flush, 1);
    idle(0, 1);
    check("reflush c2", flush, 1);
    idle(0, 1);
    check("reflush c3", flush, 1);
    idle(0, 1);
    check("reflush end", flush, 0);
    check("reflush target", imem_addr1, 32'h600);

    // Reset in the middle of a flush
    step(0, 0, 1, 1, 1, 32'h700, 0, 0, 32'h0);
    step(1, 0, 1, 0, 0, 32'h0, 0, 0, 32'h0);
    check("rstflush flush before", flush, 1);
    idle(0, 1);
    check("rstflush flush", flush, 0);
    check("rstflush pc", imem_addr1, RPC);
    check("rstflush count", redirect_count, 0);

    // Address wrap at the top of the address space
    step(0, 0, 1, 1, 1, 32'hFFFF_FFFB, 0, 0, 32'h0);
    idle(0, 1); idle(0, 1); idle(0, 1);
    check("wrap addr1", imem_addr1, 32'hFFFF_FFF8);
    check("wrap addr2", imem_addr2, 32'hFFFF_FFFC);
    idle(0, 1);
    check("wrap next pc", imem_addr1, 32'h0);
    check("wrap fetch_pc2", fetch_pc2, 32'hFFFF_FFFC);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] b1, b2;
      b1 = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      b2 = $urandom;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 1), $urandom_range(0, 9) == 0, b1,
           $urandom_range(0, 1), $urandom_range(0, 9) == 0, b2);
    end

    // Counter wrap after 65536 redirects
    step(1, 0, 1, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 65536; i++) begin
      hold_pc1 = $urandom;
      step(0, $urandom_range(0, 1), 1, 1, 1, hold_pc1, 0, 0, 32'h0);
    end
    idle(0, 1);
    check("count wrap", redirect_count, 16'h0000);
    idle(0, 1); idle(0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Dual-issue fetch PC generator and branch-redirect controller for the two-lane superscalar pipeline. It issues paired instruction-memory requests (pc, pc+4) and consumes the per-lane branch resolution (taken flag and next PC) coming back from the execute stage. It also restarts fetch at the resolved target and flushes the in-flight front-end stages. Lane 1 is always the older instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- FLUSH_CYCLES, 1, number of cycles `flush` is held after a redirect; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  decode backpressure; fetch holds while high.
- ex_valid1, ex_valid2  in  1 each  execute lane holds a valid instruction.
- isBranchTaken1, isBranchTaken2  in  1 each  lane resolved a taken branch or return.
- branchPC1, branchPC2  in  32 each  redirect target per lane.
- imem_req  out  1  request valid (combinational).
- imem_addr1, imem_addr2  out  32 each  pc and pc+4 (combinational from pc register).
- imem_ready  in  1  memory accepts the request this cycle.
- fetch_valid1, fetch_valid2  out  1 each  registered; fetched pair is valid for decode.
- fetch_pc1, fetch_pc2  out  32 each  registered PCs of the accepted pair.
- flush  out  1  registered; squash decode/issue stage contents.
- kill2  out  1  combinational; suppress lane-2 writeback (lane 1 redirected).
- redirect_count  out  16  registered count of redirects taken.

## Operation
- States: RUN, FLUSH. Reset enters RUN.
- Redirect select: if ex_valid1 && isBranchTaken1, the target is branchPC1. Otherwise, if ex_valid2 && isBranchTaken2, the target is branchPC2. Lane 1 wins when both lanes are taken.
- kill2 = ex_valid1 && isBranchTaken1, regardless of ex_valid2.
- A taken target is loaded with bits [1:0] forced to 00.
- Redirect (either state, ignores stall and imem_ready):
  - pc <= target.
  - fetch_valid1/2 <= 0.
  - flush <= 1.
  - counter <= FLUSH_CYCLES-1.
  - state <= FLUSH.
  - redirect_count increments; wraps 0xFFFF -> 0x0000.
- FLUSH, no redirect:
  - imem_req = 0.
  - Counter decrements every cycle, stall ignored.
  - When counter == 0: flush <= 0, state <= RUN.
- RUN:
  - imem_req = !stall.
  - Accept = imem_req && imem_ready. On accept: fetch_pc1 <= pc, fetch_pc2 <= pc+4, fetch_valid1/2 <= 1, pc <= pc+8.
  - If !stall and no accept: fetch_valid1/2 <= 0 (bubble); pc and fetch_pc hold.
  - If stall: pc, fetch_valid and fetch_pc all hold.
- Arithmetic is modulo 2^32.
  - From pc = 0xFFFF_FFF8: addr2 = 0xFFFF_FFFC, next pc = 0x0000_0000.
  - From pc = 0xFFFF_FFFC: addr2 = 0x0000_0000.

## Timing
- Reset values:
  - pc = RESET_PC, state = RUN, counter = 0.
  - flush = 0, fetch_valid1/2 = 0, fetch_pc1/2 = 0, redirect_count = 0.
  - imem_req = 0 while rst is high.
- rst asserted mid-FLUSH or mid-stall: all of the above restored at the next edge; any pending redirect is discarded.
- Fetch latency: accept in cycle N -> fetch_valid/fetch_pc visible in cycle N+1.
- Redirect penalty:
  - Redirect sampled at the edge ending cycle N.
  - flush is high for cycles N+1 .. N+FLUSH_CYCLES.
  - First request to the target is issued in cycle N+FLUSH_CYCLES+1.
- A redirect during FLUSH reloads pc and restarts the full FLUSH_CYCLES window.
- Simultaneous accept and redirect in the same cycle: redirect wins; the accepted pair is dropped (fetch_valid <= 0).
- imem_addr1/2 are stable while imem_req is high and imem_ready is low.

## Test plan
- Reset and streaming: RESET_PC = 0x100, imem_ready = 1, no stall -> requests at 0x100/0x104, then 0x108/0x10C. fetch_valid pairs appear one cycle after each accept; redirect_count = 0.
- Backpressure:
  - stall high for 3 cycles -> imem_req = 0, and fetch_pc/fetch_valid hold their values.
  - imem_ready low for 2 cycles -> addr stays 0x108, fetch_valid = 0 for 2 cycles, then resumes.
- Lane-1 redirect with FLUSH_CYCLES = 2:
  - Inputs: lane 1 taken to 0x2003, lane 2 taken to 0x3000.
  - Required: kill2 = 1 that cycle; flush high exactly 2 cycles; next request at 0x2000/0x2004; redirect_count = 1.
- Lane-2-only redirect: lane 1 valid but not taken, lane 2 taken to 0x400 -> kill2 = 0, target 0x400.
- Corner cases:
  - Redirect during FLUSH restarts the window with the new target.
  - Redirect while stall = 1 is still taken.
  - Redirect in the same cycle as an accept drops the accepted pair.
  - rst asserted mid-FLUSH -> flush = 0 and pc = RESET_PC on the next cycle.
- Wrap cases:
  - pc = 0xFFFF_FFF8 -> addr2 = 0xFFFF_FFFC, next pc = 0.
  - After 65536 redirects, redirect_count = 0.
